// File: rtl/c3_custom_insn_issuer_if.sv
// Bus bundle between the custom-instruction issuer, the core command/writeback
// side and the C3 SIMD unit request/response side.
interface c3_custom_insn_issuer_if #(
    parameter int VLEN = 128
);
    // cmd_*: valid/ready; a command transfers at a posedge with cmd_v & cmd_rdy high,
    // cmd_v and its fields stay stable until then. in_v, out_v and wb_v are one-cycle
    // strobes with no backpressure; their fields are meaningful only while the strobe is high.
    logic            flush;
    logic            cmd_v;
    logic            cmd_rdy;
    logic [4:0]      cmd_rd;
    logic [2:0]      cmd_vrd1;
    logic [2:0]      cmd_vrd2;
    logic [31:0]     cmd_data;
    logic [VLEN-1:0] cmd_vdata1;
    logic [VLEN-1:0] cmd_vdata2;

    logic            in_v;
    logic [4:0]      rd;
    logic [2:0]      vrd1;
    logic [2:0]      vrd2;
    logic [31:0]     in_data;
    logic [VLEN-1:0] in_vdata1;
    logic [VLEN-1:0] in_vdata2;

    logic            out_v;
    logic [4:0]      out_rd;
    logic [2:0]      out_vrd1;
    logic [2:0]      out_vrd2;
    logic [31:0]     out_data;
    logic [VLEN-1:0] out_vdata1;
    logic [VLEN-1:0] out_vdata2;

    logic            wb_v;
    logic [4:0]      wb_rd;
    logic [2:0]      wb_vrd1;
    logic [2:0]      wb_vrd2;
    logic [31:0]     wb_data;
    logic [VLEN-1:0] wb_vdata1;
    logic [VLEN-1:0] wb_vdata2;
    logic            wb_err;
    logic            busy;

    modport master (
        input  flush, cmd_v, cmd_rd, cmd_vrd1, cmd_vrd2, cmd_data, cmd_vdata1, cmd_vdata2,
        output cmd_rdy,
        output in_v, rd, vrd1, vrd2, in_data, in_vdata1, in_vdata2,
        input  out_v, out_rd, out_vrd1, out_vrd2, out_data, out_vdata1, out_vdata2,
        output wb_v, wb_rd, wb_vrd1, wb_vrd2, wb_data, wb_vdata1, wb_vdata2, wb_err, busy
    );

    modport slave (
        output flush, cmd_v, cmd_rd, cmd_vrd1, cmd_vrd2, cmd_data, cmd_vdata1, cmd_vdata2,
        input  cmd_rdy,
        input  in_v, rd, vrd1, vrd2, in_data, in_vdata1, in_vdata2,
        output out_v, out_rd, out_vrd1, out_vrd2, out_data, out_vdata1, out_vdata2,
        input  wb_v, wb_rd, wb_vrd1, wb_vrd2, wb_data, wb_vdata1, wb_vdata2, wb_err, busy
    );
endinterface

// File: rtl/c3_custom_insn_issuer.sv
// Core-side issuer for the C3 custom SIMD unit: command FIFO, credit-limited issue
// with a scalar-rd hazard scoreboard, in-order tag checking and writeback.
module c3_custom_insn_issuer #(
    parameter int VLEN    = 128,
    parameter int FIFO_D  = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    c3_custom_insn_issuer_if.master bus,
    output logic [1:0]              state_dbg
);
    localparam int AW = $clog2(FIFO_D);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef struct packed {
        logic [4:0]      rd;
        logic [2:0]      vrd1;
        logic [2:0]      vrd2;
        logic [31:0]     data;
        logic [VLEN-1:0] vdata1;
        logic [VLEN-1:0] vdata2;
    } cmd_t;

    cmd_t          fifo_mem [FIFO_D];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [10:0]   tag_mem [MAX_OUT];
    logic [TW-1:0] tq_wr, tq_rd;
    logic [CW-1:0] out_cnt;
    logic [31:0]   sb, sb_nx;
    logic [1:0]    state, state_nx;

    cmd_t head;
    logic empty, full, push, issue, rsp_ok, tag_bad;

    function automatic logic [TW-1:0] tq_next(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
    endfunction

    assign head    = fifo_mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign bus.cmd_rdy = !full && (state != S_DRAIN) && !bus.flush;
    assign push    = bus.cmd_v && bus.cmd_rdy;
    // The hazard check reads the registered scoreboard, so a response's clear
    // only unblocks the same rd from the following cycle.
    assign issue   = !empty && (out_cnt < CW'(MAX_OUT)) && (state != S_DRAIN) && !bus.flush &&
                     ((head.rd == 5'd0) || !sb[head.rd]);
    assign rsp_ok  = bus.out_v && (out_cnt != '0);
    assign tag_bad = {bus.out_rd, bus.out_vrd1, bus.out_vrd2} != tag_mem[tq_rd];
    assign bus.busy  = !empty || (out_cnt != '0);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= {bus.cmd_rd, bus.cmd_vrd1, bus.cmd_vrd2,
                                         bus.cmd_data, bus.cmd_vdata1, bus.cmd_vdata2};
        if (issue)
            tag_mem[tq_wr] <= {head.rd, head.vrd1, head.vrd2};
    end

    always_comb begin
        sb_nx = sb;
        if (rsp_ok && bus.out_rd != 5'd0) sb_nx[bus.out_rd] = 1'b0;
        if (issue && head.rd != 5'd0)     sb_nx[head.rd]    = 1'b1;
    end

    always_comb begin
        state_nx = state;
        if (bus.flush) begin
            state_nx = S_DRAIN;
        end else begin
            case (state)
                S_IDLE:  if (push) state_nx = S_RUN;
                S_RUN:   if (empty && out_cnt == '0 && !push) state_nx = S_IDLE;
                S_DRAIN: if (out_cnt == '0) state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tq_wr     <= '0;
            tq_rd     <= '0;
            out_cnt   <= '0;
            sb        <= '0;
            state     <= S_IDLE;
            bus.in_v      <= 1'b0;
            bus.rd        <= '0;
            bus.vrd1      <= '0;
            bus.vrd2      <= '0;
            bus.in_data   <= '0;
            bus.in_vdata1 <= '0;
            bus.in_vdata2 <= '0;
            bus.wb_v      <= 1'b0;
            bus.wb_rd     <= '0;
            bus.wb_vrd1   <= '0;
            bus.wb_vrd2   <= '0;
            bus.wb_data   <= '0;
            bus.wb_vdata1 <= '0;
            bus.wb_vdata2 <= '0;
            bus.wb_err    <= 1'b0;
        end else begin
            state <= state_nx;
            sb    <= sb_nx;
            // Flush drops everything still queued; push is already blocked by cmd_rdy.
            if (bus.flush) rd_ptr <= wr_ptr;
            else if (issue) rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;

            if (issue)  tq_wr <= tq_next(tq_wr);
            if (rsp_ok) tq_rd <= tq_next(tq_rd);
            if (issue && !rsp_ok)      out_cnt <= out_cnt + CW'(1);
            else if (!issue && rsp_ok) out_cnt <= out_cnt - CW'(1);

            bus.in_v <= issue;
            if (issue) begin
                bus.rd        <= head.rd;
                bus.vrd1      <= head.vrd1;
                bus.vrd2      <= head.vrd2;
                bus.in_data   <= head.data;
                bus.in_vdata1 <= head.vdata1;
                bus.in_vdata2 <= head.vdata2;
            end

            bus.wb_v <= rsp_ok;
            if (rsp_ok) begin
                bus.wb_rd     <= bus.out_rd;
                bus.wb_vrd1   <= bus.out_vrd1;
                bus.wb_vrd2   <= bus.out_vrd2;
                bus.wb_data   <= bus.out_data;
                bus.wb_vdata1 <= bus.out_vdata1;
                bus.wb_vdata2 <= bus.out_vdata2;
            end
            if (bus.out_v && (out_cnt == '0 || tag_bad)) bus.wb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_c3_custom_insn_issuer.sv
// Bench for c3_custom_insn_issuer: directed scenarios plus a random phase, with an
// order-based reference model of the issue/response protocol and a negedge monitor.
module tb_c3_custom_insn_issuer;
    localparam int VLEN    = 128;
    localparam int FIFO_D  = 4;
    localparam int MAX_OUT = 2;
    localparam int W       = 11 + 32 + 2 * VLEN;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state_dbg;
    int         cyc = 0;

    c3_custom_insn_issuer_if #(.VLEN(VLEN)) bus();

    c3_custom_insn_issuer #(.VLEN(VLEN), .FIFO_D(FIFO_D), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard / model state ----------------
    logic [W-1:0] exp_req_q[$];
    logic [W-1:0] exp_wb_q[$];
    logic [W-1:0] pend_q[$];
    logic [W-1:0] man_q[$];
    logic [10:0]  tag_q[$];
    bit           inflight [32];
    int           model_out = 0;
    bit           exp_err = 0;
    bit           unit_auto = 0;
    int           checks = 0, errors = 0;
    int           inv_cnt = 0, wb_cnt = 0;
    int           acc_cyc = 0, last_inv_cyc = 0, last_out_cyc = 0;
    logic [4:0]   last_wb_rd;
    logic [31:0]  last_wb_data;

    function automatic logic [W-1:0] pack(input logic [4:0] r, input logic [2:0] v1, input logic [2:0] v2,
                                          input logic [31:0] d, input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
        return {r, v1, v2, d, a, b};
    endfunction

    // The unit's behaviour: echo the tags, transform the operands.
    function automatic logic [W-1:0] make_resp(input logic [W-1:0] p);
        logic [VLEN-1:0] a;
        logic [VLEN-1:0] b;
        a = p[2*VLEN-1 -: VLEN];
        b = p[VLEN-1:0];
        return {p[W-1 -: 11], p[W-12 -: 32] ^ 32'h5A5A_0F0F, a + VLEN'(1), ~b};
    endfunction

    function automatic logic [VLEN-1:0] rand_v();
        logic [VLEN-1:0] v;
        for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name, input int got, input int need);
        checks++;
        errors++;
        $display("FAIL %s: timed out with %0d, required %0d", name, got, need);
    endtask

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.cmd_v = 1'b0;
        unit_auto = 1'b0;
        step(3);
        exp_req_q.delete();
        exp_wb_q.delete();
        pend_q.delete();
        man_q.delete();
        tag_q.delete();
        foreach (inflight[i]) inflight[i] = 1'b0;
        model_out = 0;
        exp_err = 1'b0;
        reset = 1'b0;
    endtask

    task automatic push_cmd(input logic [4:0] r, input logic [2:0] v1, input logic [2:0] v2,
                            input logic [31:0] d, input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
        int n = 0;
        bus.cmd_v = 1'b1;
        bus.cmd_rd = r;
        bus.cmd_vrd1 = v1;
        bus.cmd_vrd2 = v2;
        bus.cmd_data = d;
        bus.cmd_vdata1 = a;
        bus.cmd_vdata2 = b;
        while (!bus.cmd_rdy && n < 300) begin
            step(1);
            n++;
        end
        if (!bus.cmd_rdy) begin
            bus.cmd_v = 1'b0;
            timeout("cmd_accept", n, 300);
        end else begin
            exp_req_q.push_back(pack(r, v1, v2, d, a, b));
            acc_cyc = cyc;
            step(1);
            bus.cmd_v = 1'b0;
        end
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        step(1);
        bus.flush = 1'b0;
        // Everything accepted but not yet seen on in_v is dropped.
        exp_req_q.delete();
    endtask

    task automatic wait_inv(input int target, input string name);
        int n = 0;
        while (inv_cnt < target && n < 500) begin step(1); n++; end
        if (inv_cnt < target) timeout(name, inv_cnt, target);
    endtask

    task automatic wait_wb(input int target, input string name);
        int n = 0;
        while (wb_cnt < target && n < 1000) begin step(1); n++; end
        if (wb_cnt < target) timeout(name, wb_cnt, target);
    endtask

    task automatic wait_pend(input string name);
        int n = 0;
        while (pend_q.size() == 0 && n < 500) begin step(1); n++; end
        if (pend_q.size() == 0) timeout(name, 0, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((bus.busy || exp_wb_q.size() != 0 || pend_q.size() != 0) && n < 3000) begin step(1); n++; end
        if (bus.busy || exp_wb_q.size() != 0) timeout(name, n, 3000);
    endtask

    // ---------------- unit responder ----------------
    task automatic drive_out(input logic [W-1:0] p);
        bus.out_v      = 1'b1;
        bus.out_rd     = p[W-1 -: 5];
        bus.out_vrd1   = p[W-6 -: 3];
        bus.out_vrd2   = p[W-9 -: 3];
        bus.out_data   = p[W-12 -: 32];
        bus.out_vdata1 = p[2*VLEN-1 -: VLEN];
        bus.out_vdata2 = p[VLEN-1:0];
    endtask

    initial begin
        bus.out_v = 1'b0;
        bus.out_rd = '0;
        bus.out_vrd1 = '0;
        bus.out_vrd2 = '0;
        bus.out_data = '0;
        bus.out_vdata1 = '0;
        bus.out_vdata2 = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_v = 1'b0;
            if (!reset) begin
                if (man_q.size() > 0) drive_out(man_q.pop_front());
                else if (unit_auto && pend_q.size() > 0 && $urandom_range(0, 2) == 0)
                    drive_out(make_resp(pend_q.pop_front()));
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] got;
        logic [W-1:0] e;
        logic [10:0]  t;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.wb_v) begin
                    got = pack(bus.wb_rd, bus.wb_vrd1, bus.wb_vrd2, bus.wb_data, bus.wb_vdata1, bus.wb_vdata2);
                    if (exp_wb_q.size() == 0) timeout("wb_unexpected", 1, 0);
                    else begin
                        e = exp_wb_q.pop_front();
                        check("wb_fields", got, e);
                    end
                    check("wb_err_at_wb", W'(bus.wb_err), W'(exp_err));
                    last_wb_rd = bus.wb_rd;
                    last_wb_data = bus.wb_data;
                    wb_cnt++;
                end
                if (bus.in_v) begin
                    got = pack(bus.rd, bus.vrd1, bus.vrd2, bus.in_data, bus.in_vdata1, bus.in_vdata2);
                    if (exp_req_q.size() == 0) timeout("in_v_unexpected", 1, 0);
                    else begin
                        e = exp_req_q.pop_front();
                        check("req_fields", got, e);
                    end
                    check("req_rd_hazard", W'(bus.rd != 5'd0 && inflight[bus.rd]), W'(0));
                    check("req_credit", W'(model_out >= MAX_OUT), W'(0));
                    model_out++;
                    if (bus.rd != 5'd0) inflight[bus.rd] = 1'b1;
                    tag_q.push_back({bus.rd, bus.vrd1, bus.vrd2});
                    pend_q.push_back(got);
                    last_inv_cyc = cyc;
                    inv_cnt++;
                end
                if (bus.out_v) begin
                    last_out_cyc = cyc;
                    if (model_out == 0) exp_err = 1'b1;
                    else begin
                        model_out--;
                        t = tag_q.pop_front();
                        if (t != {bus.out_rd, bus.out_vrd1, bus.out_vrd2}) exp_err = 1'b1;
                        inflight[bus.out_rd] = 1'b0;
                        exp_wb_q.push_back(pack(bus.out_rd, bus.out_vrd1, bus.out_vrd2,
                                                bus.out_data, bus.out_vdata1, bus.out_vdata2));
                    end
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [W-1:0] r;
        int base_inv, base_wb;
        bus.cmd_rd = '0;
        bus.cmd_vrd1 = '0;
        bus.cmd_vrd2 = '0;
        bus.cmd_data = '0;
        bus.cmd_vdata1 = '0;
        bus.cmd_vdata2 = '0;
        reset_dut();

        // Reset values
        check("rst_in_v", W'(bus.in_v), W'(0));
        check("rst_wb_v", W'(bus.wb_v), W'(0));
        check("rst_busy", W'(bus.busy), W'(0));
        check("rst_wb_err", W'(bus.wb_err), W'(0));
        check("rst_cmd_rdy", W'(bus.cmd_rdy), W'(1));
        check("rst_state", W'(state_dbg), W'(0));

        // Single command, manual unit response
        push_cmd(5'd5, 3'd0, 3'd0, 32'hA5, '0, '0);
        wait_pend("t2_in_v");
        check("t2_latency", W'(last_inv_cyc - acc_cyc), W'(2));
        r = pend_q.pop_front();
        man_q.push_back(pack(5'd5, 3'd0, 3'd0, 32'h5A, '0, '0));
        wait_wb(1, "t2_wb");
        check("t2_wb_rd", W'(last_wb_rd), W'(5));
        check("t2_wb_data", W'(last_wb_data), W'(32'h5A));
        step(2);
        check("t2_busy_low", W'(bus.busy), W'(0));
        check("t2_state_idle", W'(state_dbg), W'(0));

        // Credit limit and full FIFO with a silent unit
        reset_dut();
        base_inv = inv_cnt;
        base_wb = wb_cnt;
        for (int i = 1; i <= 6; i++)
            push_cmd(5'(i), 3'(i), 3'(7 - i), $urandom, rand_v(), rand_v());
        step(4);
        check("t3_full_rdy", W'(bus.cmd_rdy), W'(0));
        check("t3_in_v_limit", W'(inv_cnt - base_inv), W'(MAX_OUT));
        unit_auto = 1'b1;
        wait_wb(base_wb + 6, "t3_all_wb");
        wait_idle("t3_idle");
        check("t3_req_drained", W'(exp_req_q.size()), W'(0));

        // rd hazard: second rd=7 waits for the first response
        reset_dut();
        base_inv = inv_cnt;
        push_cmd(5'd7, 3'd1, 3'd2, 32'h1111, rand_v(), rand_v());
        push_cmd(5'd7, 3'd3, 3'd4, 32'h2222, rand_v(), rand_v());
        step(6);
        check("t4_withheld", W'(inv_cnt - base_inv), W'(1));
        wait_pend("t4_first");
        man_q.push_back(make_resp(pend_q.pop_front()));
        wait_inv(base_inv + 2, "t4_second");
        check("t4_reissue_gap", W'(last_inv_cyc - last_out_cyc), W'(2));
        unit_auto = 1'b1;
        wait_idle("t4_idle");

        // Flush with queued and outstanding commands
        reset_dut();
        base_inv = inv_cnt;
        for (int i = 1; i <= 5; i++)
            push_cmd(5'(i + 8), 3'(i), 3'(i), $urandom, rand_v(), rand_v());
        step(3);
        check("t5_out_before", W'(inv_cnt - base_inv), W'(2));
        base_wb = wb_cnt;
        do_flush();
        step(4);
        check("t5_state_drain", W'(state_dbg), W'(2));
        check("t5_rdy_drain", W'(bus.cmd_rdy), W'(0));
        unit_auto = 1'b1;
        wait_wb(base_wb + 2, "t5_wb");
        step(4);
        check("t5_no_new_in_v", W'(inv_cnt - base_inv), W'(2));
        check("t5_wb_count", W'(wb_cnt - base_wb), W'(2));
        check("t5_busy", W'(bus.busy), W'(0));
        check("t5_state_idle", W'(state_dbg), W'(0));

        // Unexpected response and tag mismatch set the sticky error
        reset_dut();
        base_wb = wb_cnt;
        man_q.push_back(pack(5'd9, 3'd1, 3'd1, 32'hDEAD, '0, '0));
        step(4);
        check("t6_err_unexp", W'(bus.wb_err), W'(1));
        check("t6_no_wb", W'(wb_cnt - base_wb), W'(0));
        step(10);
        check("t6_err_sticky", W'(bus.wb_err), W'(1));
        reset_dut();
        check("t6_err_reset", W'(bus.wb_err), W'(0));
        base_wb = wb_cnt;
        push_cmd(5'd3, 3'd2, 3'd5, 32'h3333, rand_v(), rand_v());
        wait_pend("t6_issue");
        r = make_resp(pend_q.pop_front());
        r[W-1 -: 5] = 5'd4;
        man_q.push_back(r);
        wait_wb(base_wb + 1, "t6_wb");
        check("t6_mismatch_wb_rd", W'(last_wb_rd), W'(4));
        check("t6_err_mismatch", W'(bus.wb_err), W'(1));

        // Random traffic with hazards, back-pressure and occasional flushes
        reset_dut();
        unit_auto = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 2));
            if ($urandom_range(0, 14) == 0) do_flush();
            push_cmd(5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     $urandom, rand_v(), rand_v());
        end
        step(4);
        wait_idle("rand_idle");
        step(4);
        check("rand_req_empty", W'(exp_req_q.size()), W'(0));
        check("rand_wb_empty", W'(exp_wb_q.size()), W'(0));
        check("rand_busy", W'(bus.busy), W'(0));
        check("rand_state", W'(state_dbg), W'(0));
        check("rand_wb_err", W'(bus.wb_err), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
